// File: rtl/noc_input_unit.sv
// Local-injection input unit: FWFT flit FIFO plus XY route computation that
// latches the output port on the packet header and holds it until the tail leaves.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no packet open; stray non-header flits at the head are dropped
// ACTIVE | route latched; head flits are offered to the switch until the tail

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_input_unit #(
  parameter int                    ID_X_WIDTH = 4,
  parameter int                    ID_Y_WIDTH = 4,
  parameter logic [ID_X_WIDTH-1:0] X_ID       = '0,
  parameter logic [ID_Y_WIDTH-1:0] Y_ID       = '0,
  parameter int                    DATA_WIDTH = `Noc_Data_Width,
  parameter int                    DEPTH      = 4
) (
  input  logic                         noc_clk,
  input  logic                         noc_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_flit,
  input  logic                         in_is_header,
  input  logic                         in_is_tail,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_flit,
  output logic                         out_is_header,
  output logic                         out_is_tail,
  output logic [4:0]                   out_route,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         err_drop,
  output logic                         err_hdr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int ENT_W = DATA_WIDTH + 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [4:0]              route_q, route_d;
  logic                    first_q, first_d;
  logic                    rdy_q;
  logic                    err_drop_q, err_drop_d;
  logic                    err_hdr_q, err_hdr_d;
  logic [ENT_W-1:0]        mem_q [DEPTH];

  logic                    full, empty, push, pop, head_valid;
  logic [ENT_W-1:0]        head;
  logic [DATA_WIDTH-1:0]   head_flit;
  logic                    head_hdr, head_tail;
  logic [ID_X_WIDTH-1:0]   dest_x;
  logic [ID_Y_WIDTH-1:0]   dest_y;
  logic [4:0]              route_calc;

  always_comb begin
    full      = (occ_q == OCC_W'(DEPTH));
    empty     = (occ_q == '0);
    head      = mem_q[rd_ptr_q];
    head_flit = head[ENT_W-1:2];
    head_hdr  = head[1];
    head_tail = head[0];
    push      = in_valid & in_ready;
    dest_x    = head_flit[DATA_WIDTH-1 -: ID_X_WIDTH];
    dest_y    = head_flit[DATA_WIDTH-1-ID_X_WIDTH -: ID_Y_WIDTH];
  end

  // Dimension-ordered: resolve X completely before looking at Y.
  always_comb begin
    route_calc = 5'b00001;
    if (dest_x > X_ID)      route_calc = 5'b00010;
    else if (dest_x < X_ID) route_calc = 5'b00100;
    else if (dest_y > Y_ID) route_calc = 5'b01000;
    else if (dest_y < Y_ID) route_calc = 5'b10000;
  end

  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    first_d    = first_q;
    pop        = 1'b0;
    head_valid = 1'b0;
    err_drop_d = 1'b0;
    err_hdr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (head_hdr) begin
            route_d = route_calc;
            first_d = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            pop        = 1'b1;
            err_drop_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        head_valid = !empty;
        if (head_valid && out_ready) begin
          pop     = 1'b1;
          first_d = 1'b0;
          if (head_hdr && !first_q) err_hdr_d = 1'b1;
          if (head_tail)            state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      route_q    <= '0;
      first_q    <= 1'b0;
      rdy_q      <= 1'b0;
      err_drop_q <= 1'b0;
      err_hdr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      route_q    <= route_d;
      first_q    <= first_d;
      rdy_q      <= 1'b1;
      err_drop_q <= err_drop_d;
      err_hdr_q  <= err_hdr_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge noc_clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_flit, in_is_header, in_is_tail};
  end

  assign in_ready      = rdy_q & !full;
  assign out_valid     = head_valid;
  assign out_flit      = head_valid ? head_flit : '0;
  assign out_is_header = head_valid & head_hdr;
  assign out_is_tail   = head_valid & head_tail;
  assign out_route     = (state_q == ST_ACTIVE) ? route_q : 5'b00000;
  assign occupancy     = occ_q;
  assign err_drop      = err_drop_q;
  assign err_hdr       = err_hdr_q;

endmodule

// File: tb/tb_noc_input_unit.sv
// Directed bench for noc_input_unit at router (1,1), DEPTH 4: vector table for
// packet flow and routing, hand sequences for backpressure, drop, reset, bad header.

module tb_noc_input_unit;

  logic        noc_clk;
  logic        noc_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_flit;
  logic        in_is_header;
  logic        in_is_tail;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_flit;
  logic        out_is_header;
  logic        out_is_tail;
  logic [4:0]  out_route;
  logic [2:0]  occupancy;
  logic        err_drop;
  logic        err_hdr;

  int checks = 0;
  int errors = 0;

  noc_input_unit #(
    .ID_X_WIDTH(4), .ID_Y_WIDTH(4), .X_ID(4'd1), .Y_ID(4'd1),
    .DATA_WIDTH(32), .DEPTH(4)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .out_route(out_route), .occupancy(occupancy),
    .err_drop(err_drop), .err_hdr(err_hdr)
  );

  initial begin
    noc_clk = 1'b0;
    forever #5 noc_clk = ~noc_clk;
  end

  typedef struct {
    logic        v;
    logic [31:0] f;
    logic        h;
    logic        t;
    logic        r;
    logic        e_ov;
    logic [31:0] e_flit;
    logic        e_h;
    logic        e_t;
    logic [4:0]  e_route;
    logic [2:0]  e_occ;
    logic        e_rdy;
    logic        e_drop;
    logic        e_herr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies inputs just after the falling edge; outputs are then sampled well
  // before the next rising edge, so they reflect the state from the last edge.
  task automatic drive(input logic v, input logic [31:0] f, input logic h,
                       input logic t, input logic r);
    @(negedge noc_clk);
    in_valid = v; in_flit = f; in_is_header = h; in_is_tail = t; out_ready = r;
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic ov, input logic [31:0] fl,
                             input logic h, input logic t, input logic [4:0] rt,
                             input logic [2:0] oc, input logic rdy,
                             input logic dr, input logic he);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    if (ov) begin
      chk({tag, " out_flit"}, out_flit, fl);
      chk({tag, " out_is_header"}, 32'(out_is_header), 32'(h));
      chk({tag, " out_is_tail"}, 32'(out_is_tail), 32'(t));
    end
    chk({tag, " out_route"}, 32'(out_route), 32'(rt));
    chk({tag, " occupancy"}, 32'(occupancy), 32'(oc));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, " err_drop"}, 32'(err_drop), 32'(dr));
    chk({tag, " err_hdr"}, 32'(err_hdr), 32'(he));
  endtask

  function automatic vec_t mk(logic v, logic [31:0] f, logic h, logic t, logic r,
                              logic e_ov, logic [31:0] e_flit, logic e_h, logic e_t,
                              logic [4:0] e_route, logic [2:0] e_occ, logic e_rdy);
    vec_t x;
    x.v = v; x.f = f; x.h = h; x.t = t; x.r = r;
    x.e_ov = e_ov; x.e_flit = e_flit; x.e_h = e_h; x.e_t = e_t;
    x.e_route = e_route; x.e_occ = e_occ; x.e_rdy = e_rdy;
    x.e_drop = 1'b0; x.e_herr = 1'b0;
    return x;
  endfunction

  initial begin
    in_valid = 0; in_flit = '0; in_is_header = 0; in_is_tail = 0; out_ready = 0;
    noc_rst_n = 0;

    // 3-flit packet to (3,0): east
    vecs.push_back(mk(1, 32'h3000_0011, 1, 0, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd0, 1));
    vecs.push_back(mk(1, 32'h0000_0022, 0, 0, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd1, 1));
    vecs.push_back(mk(1, 32'h0000_0033, 0, 1, 1,  1, 32'h3000_0011,  1, 0, 5'b00010, 3'd2, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  1, 32'h0000_0022,  0, 0, 5'b00010, 3'd2, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  1, 32'h0000_0033,  0, 1, 5'b00010, 3'd1, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd0, 1));
    // back-to-back single-flit packets: local, west, north, south
    vecs.push_back(mk(1, 32'h1100_0001, 1, 1, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd0, 1));
    vecs.push_back(mk(1, 32'h0100_0002, 1, 1, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd1, 1));
    vecs.push_back(mk(1, 32'h1200_0003, 1, 1, 1,  1, 32'h1100_0001,  1, 1, 5'b00001, 3'd2, 1));
    vecs.push_back(mk(1, 32'h1000_0004, 1, 1, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd2, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  1, 32'h0100_0002,  1, 1, 5'b00100, 3'd3, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd2, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  1, 32'h1200_0003,  1, 1, 5'b01000, 3'd2, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd1, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  1, 32'h1000_0004,  1, 1, 5'b10000, 3'd1, 1));
    vecs.push_back(mk(0, 32'h0,         0, 0, 1,  0, 32'h0,          0, 0, 5'b00000, 3'd0, 1));

    // reset state
    #12;
    expect_outs("reset", 0, 32'h0, 0, 0, 5'b0, 3'd0, 0, 0, 0);
    chk("reset out_flit", out_flit, 32'h0);
    @(negedge noc_clk);
    #2 noc_rst_n = 1;
    #1 chk("post-release in_ready low", 32'(in_ready), 32'd0);
    @(posedge noc_clk);
    #1 chk("first cycle in_ready high", 32'(in_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].f, vecs[i].h, vecs[i].t, vecs[i].r);
      expect_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_flit, vecs[i].e_h,
                  vecs[i].e_t, vecs[i].e_route, vecs[i].e_occ, vecs[i].e_rdy,
                  vecs[i].e_drop, vecs[i].e_herr);
    end

    // fill to DEPTH with the switch stalled, then release for one cycle
    drive(1, 32'h3000_00A0, 1, 0, 0);
    drive(1, 32'h0000_00A1, 0, 0, 0);
    drive(1, 32'h0000_00A2, 0, 0, 0);
    expect_outs("fill2", 1, 32'h3000_00A0, 1, 0, 5'b00010, 3'd2, 1, 0, 0);
    drive(1, 32'h0000_00A3, 0, 0, 0);
    drive(1, 32'h0000_00A4, 0, 1, 0);
    expect_outs("full", 1, 32'h3000_00A0, 1, 0, 5'b00010, 3'd4, 0, 0, 0);
    drive(1, 32'h0000_00A4, 0, 1, 1);
    expect_outs("full pop", 1, 32'h3000_00A0, 1, 0, 5'b00010, 3'd4, 0, 0, 0);
    drive(1, 32'h0000_00A4, 0, 1, 0);
    expect_outs("after pop", 1, 32'h0000_00A1, 0, 0, 5'b00010, 3'd3, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("drain1", 1, 32'h0000_00A1, 0, 0, 5'b00010, 3'd4, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("drain2", 1, 32'h0000_00A2, 0, 0, 5'b00010, 3'd3, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("drain3", 1, 32'h0000_00A3, 0, 0, 5'b00010, 3'd2, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("drain4", 1, 32'h0000_00A4, 0, 1, 5'b00010, 3'd1, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("drained", 0, 32'h0, 0, 0, 5'b0, 3'd0, 1, 0, 0);

    // stray body flit with no header is dropped
    drive(1, 32'hDEAD_BEEF, 0, 0, 1);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("stray held", 0, 32'h0, 0, 0, 5'b0, 3'd1, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("stray dropped", 0, 32'h0, 0, 0, 5'b0, 3'd0, 1, 1, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("drop one pulse", 0, 32'h0, 0, 0, 5'b0, 3'd0, 1, 0, 0);

    // reset mid-packet after 2 of 4 flits
    drive(1, 32'h3000_00C0, 1, 0, 0);
    drive(1, 32'h0000_00C1, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    expect_outs("pre-reset", 1, 32'h3000_00C0, 1, 0, 5'b00010, 3'd2, 1, 0, 0);
    noc_rst_n = 0;
    #1;
    expect_outs("mid reset", 0, 32'h0, 0, 0, 5'b0, 3'd0, 0, 0, 0);
    chk("mid reset out_flit", out_flit, 32'h0);
    @(negedge noc_clk);
    #2 noc_rst_n = 1;
    drive(1, 32'h1200_00D0, 1, 1, 1);
    expect_outs("after reset", 0, 32'h0, 0, 0, 5'b0, 3'd0, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("new hdr wait", 0, 32'h0, 0, 0, 5'b0, 3'd1, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("new hdr out", 1, 32'h1200_00D0, 1, 1, 5'b01000, 3'd1, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("no stale", 0, 32'h0, 0, 0, 5'b0, 3'd0, 1, 0, 0);

    // second header inside an open packet
    drive(1, 32'h3000_00E0, 1, 0, 1);
    drive(1, 32'h1100_00E1, 1, 0, 1);
    drive(1, 32'h0000_00E2, 0, 1, 1);
    expect_outs("dbl hdr1", 1, 32'h3000_00E0, 1, 0, 5'b00010, 3'd2, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("dbl hdr2", 1, 32'h1100_00E1, 1, 0, 5'b00010, 3'd2, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("dbl tail", 1, 32'h0000_00E2, 0, 1, 5'b00010, 3'd1, 1, 0, 1);
    drive(0, 32'h0, 0, 0, 1);
    expect_outs("dbl done", 0, 32'h0, 0, 0, 5'b0, 3'd0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_input_unit.md
# noc_input_unit

Router input unit for the local injection port: accepts flits from a node's sender interface (valid/ready plus header/tail sideband), buffers them in a small FIFO, and computes the dimension-ordered (XY) output port for each packet from its header flit. It holds that route until the packet's tail flit leaves. It sits directly downstream of a node's sender port and upstream of the router switch allocator and crossbar.

## Interface
- X_ID, 0: router X coordinate, Noc_ID_X_Width bits.
- Y_ID, 0: router Y coordinate, Noc_ID_Y_Width bits.
- DATA_WIDTH, `Noc_Data_Width: flit width.
- DEPTH, 4: FIFO depth in flits; power of two, ≥2.
- noc_clk  in  1  clock; all logic on the rising edge.
- noc_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream flit valid.
- in_ready  out  1  unit can accept a flit.
- in_flit  in  DATA_WIDTH  upstream flit.
- in_is_header  in  1  flit is a packet header.
- in_is_tail  in  1  flit is a packet tail; a single-flit packet has both header and tail set.
- out_valid  out  1  head flit available to the switch.
- out_ready  in  1  switch consumes the head flit.
- out_flit  out  DATA_WIDTH  head flit.
- out_is_header, out_is_tail  out  1 each  sideband of the head flit.
- out_route  out  5  one-hot port: [0] local, [1] east (X+), [2] west (X−), [3] north (Y+), [4] south (Y−).
- occupancy  out  $clog2(DEPTH+1)  flits stored.
- err_drop  out  1  one-cycle pulse: a stray non-header flit was discarded.
- err_hdr  out  1  one-cycle pulse: a header was forwarded mid-packet.

## Operation
- Header format: dest_x = flit[DATA_WIDTH-1 -: Noc_ID_X_Width]; dest_y is the next Noc_ID_Y_Width bits below dest_x.
- The FIFO stores {flit, is_header, is_tail}. Write on in_valid&in_ready. Read on out_valid&out_ready, or on a drop.
- in_ready = !full. Push while full is refused, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full or empty: occupancy is unchanged. Pointers wrap modulo DEPTH.
- Route computation is unsigned and compares X before Y:
  - dest_x > X_ID: east.
  - dest_x < X_ID: west.
  - X equal, dest_y > Y_ID: north.
  - X equal, dest_y < Y_ID: south.
  - Both equal: local.
- State machine:
  - IDLE: out_valid = 0, out_route = 0.
    - FIFO non-empty and head is a header: latch the route, go to ACTIVE.
    - FIFO non-empty and head is not a header: pop it, pulse err_drop, stay in IDLE.
  - ACTIVE: out_valid = !empty; out_route holds the latched value.
    - A popped flit with is_tail = 1 returns the machine to IDLE.
    - A popped flit with is_header = 1 other than the first flit of the packet is forwarded and pulses err_hdr.
- Out data is taken from the FIFO head (first-word-fall-through).
- out_flit/out_is_* are don't-care when out_valid = 0.

## Timing
- Reset (asynchronous, while noc_rst_n = 0):
  - in_ready = 0; it rises the first cycle after release.
  - out_valid, out_route, occupancy, err_drop, err_hdr = 0.
  - out_flit, out_is_header, out_is_tail = 0.
  - State = IDLE; pointers = 0.
- Reset mid-packet discards all buffered flits and the latched route.
- Header write at edge E into an empty IDLE unit:
  - Route latched at edge E+1.
  - out_valid and out_route valid after E+1, i.e. 2-cycle latency.
- Body flit latency in ACTIVE: out_valid the cycle after the write edge.
- Tail pop at edge T with the next header already at head: route latched at T+1. There is exactly one idle cycle between packets.
- The head flit and out_route stay stable while out_valid & !out_ready.
- Full/empty are derived from occupancy only. Full: occupancy = DEPTH. Empty: occupancy = 0.
- Error pulses are registered, asserted the cycle after the offending pop.

## Test plan
- X_ID=1, Y_ID=1. Send a 3-flit packet to (3,0), header/body/tail, with out_ready=1. Required: out_route=5'b00010 from the cycle after header latch until tail pop; 3 flits out in order; return to IDLE.
- Fill DEPTH=4 with out_ready=0 and in_valid held high. Required: occupancy=4 and in_ready=0. Then out_ready=1 for one cycle: occupancy=3, in_ready=1 the next cycle, and no flit is lost or duplicated.
- Send back-to-back single-flit packets to (1,1), (0,1), (1,2), (1,0). Required: routes in order 00001, 00100, 01000, 10000, with one idle cycle between them.
- Inject a body flit with no preceding header (value 32'hDEAD_BEEF). Required: it never appears on out_flit, err_drop pulses once, and occupancy returns to 0.
- Assert reset mid-packet after 2 of 4 flits. Required: all outputs 0 immediately; after release, a new header is routed correctly and no stale flit appears.
- Send a header, then a second header before any tail. Required: the second header is forwarded on the first route and err_hdr pulses once.
